// File: rtl/fifo_param_pkg.sv
// Shared defaults and the address-width helper for the parametrised FIFO
// and the blocks that sit next to it.
package fifo_param_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AF_LEVEL = 6;
    localparam int DEF_AE_LEVEL = 2;

    // Smallest n with 2**n >= depth; exact log2 for the power-of-two depths used here.
    function automatic int addr_bits(input int depth);
        int n;
        n = 0;
        while ((1 << n) < depth) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// No reset; the read register only updates when a read is requested.
module fifo_mem
    import fifo_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = addr_bits(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Read-before-write: a same-address read/write (full FIFO) returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int AW      = addr_bits(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             WRITE,
    input  logic             READ,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             Valid,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic [AW:0]      COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic             r_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_rd_seen;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [WIDTH-1:0] w_mem_q;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_rd_acc  = READ && !w_empty;
    assign w_wr_acc  = WRITE && (!w_full || w_rd_acc);
    assign w_ovf_evt = WRITE && w_full && !READ;
    assign w_udf_evt = READ && w_empty;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + (AW+1)'(1);
            2'b01:   w_count_next = r_count - (AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rd_seen   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_seen <= 1'b1;
            end
            r_count <= w_count_next;
            r_valid <= w_rd_acc;
            // A new error in the clearing cycle wins over ERR_CLR.
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (ERR_CLR) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_evt) begin
                r_underflow <= 1'b1;
            end else if (ERR_CLR) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (CLK),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (DATA_IN),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_q)
    );

    // The array read register has no reset, so DATA_OUT is forced to zero until the first read.
    assign DATA_OUT     = r_rd_seen ? w_mem_q : '0;
    assign Valid        = r_valid;
    assign FULL         = w_full;
    assign EMPTY        = w_empty;
    assign ALMOST_FULL  = (r_count >= AF_C);
    assign ALMOST_EMPTY = (r_count <= AE_C);
    assign COUNT        = r_count;
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a reference queue models the FIFO and a
// scoreboard queue holds the words expected on DATA_OUT one cycle after each read.
module tb_fifo_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] dout;
    logic       valid;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic [3:0] count;
    logic       ovf;
    logic       udf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q [$];
    logic [7:0] sb_q [$];
    logic       m_ovf;
    logic       m_udf;
    logic [7:0] m_dout;

    fifo_param #(
        .WIDTH    (8),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .DATA_IN      (din),
        .WRITE        (wr),
        .READ         (rd),
        .ERR_CLR      (clr),
        .DATA_OUT     (dout),
        .Valid        (valid),
        .FULL         (full),
        .EMPTY        (empty),
        .ALMOST_FULL  (afull),
        .ALMOST_EMPTY (aempty),
        .COUNT        (count),
        .OVERFLOW     (ovf),
        .UNDERFLOW    (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".afull"}, 32'(afull), 32'(n >= 6));
        chk({tag, ".aempty"}, 32'(aempty), 32'(n <= 2));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
    endtask

    task automatic model_reset();
        model_q.delete();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = 8'h00;
    endtask

    // One clock: drive, update the model from its pre-edge state, then check after the edge.
    task automatic cycle(input string tag, input logic w, input logic [7:0] d,
                         input logic r, input logic c);
        logic rd_acc;
        logic wr_acc;
        logic ovf_evt;
        logic udf_evt;
        logic [7:0] exp;
        wr  = w;
        din = d;
        rd  = r;
        clr = c;
        rd_acc  = r && (model_q.size() != 0);
        wr_acc  = w && ((model_q.size() < 8) || rd_acc);
        ovf_evt = w && (model_q.size() == 8) && !r;
        udf_evt = r && (model_q.size() == 0);
        if (rd_acc) begin
            exp = model_q.pop_front();
            sb_q.push_back(exp);
            m_dout = exp;
        end
        if (wr_acc) model_q.push_back(d);
        m_ovf = ovf_evt ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = udf_evt ? 1'b1 : (c ? 1'b0 : m_udf);
        @(posedge clk);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        chk({tag, ".valid"}, 32'(valid), 32'(rd_acc));
        if (rd_acc) begin
            exp = sb_q.pop_front();
            chk({tag, ".dout"}, 32'(dout), 32'(exp));
            $display("read  %s data=%02h count=%0d", tag, dout, count);
        end else begin
            chk({tag, ".dout_hold"}, 32'(dout), 32'(m_dout));
        end
        if (wr_acc) $display("write %s data=%02h count=%0d", tag, d, count);
        chk_flags(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".dout"}, 32'(dout), 32'd0);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".full"}, 32'(full), 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".afull"}, 32'(afull), 32'd0);
        chk({tag, ".aempty"}, 32'(aempty), 32'd1);
        chk({tag, ".ovf"}, 32'(ovf), 32'd0);
        chk({tag, ".udf"}, 32'(udf), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        clr   = 1'b0;
        din   = 8'h00;
        model_reset();

        #22;
        chk_reset_vals("reset");
        $display("reset checked at time %0t", $time);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x10..0x17, then overflow with 0xAA and clear it.
        for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cycle("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
        cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Full: simultaneous read/write is accepted with no overflow; 0x55 comes out last.
        cycle("full_rw", 1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow, underflow coinciding with ERR_CLR, then a plain clear.
        cycle("udf", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("udf_clr_same", 1'b0, 8'h00, 1'b1, 1'b1);
        cycle("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Empty: simultaneous read/write accepts only the write, no bypass.
        cycle("empty_rw", 1'b1, 8'h66, 1'b1, 1'b0);
        cycle("empty_rw_rd", 1'b0, 8'h00, 1'b1, 1'b1);

        // Interleaved traffic to wrap the pointers several times.
        for (int i = 0; i < 20; i++) begin
            cycle("wrap", 1'b1, 8'($urandom_range(255)), (i % 3) != 0, 1'b0);
        end
        while (model_q.size() > 3) cycle("to3", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset with COUNT=3 and a read result in flight.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_vals("midreset");
        $display("mid-stream reset checked at time %0t", $time);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_wr", 1'b1, 8'hC3, 1'b0, 1'b0);
        cycle("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("post_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
